// File: rtl/aibcr3_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aibcr3_scan_pkg
// Description : Shared types and encodings for the AIB scan-chain sequencer.
//               Holds the sequencer state enum and the operation codes that
//               software presents on OP together with START.
// Revision    : 1.0 - initial release
// ============================================================================
package aibcr3_scan_pkg;

    // Sequencer states; explicit 3-bit encoding keeps the state register
    // width fixed regardless of tool enum sizing.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CAP   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_PRE   = 3'd3,
        ST_FIN   = 3'd4
    } scan_state_e;

    // Operation codes sampled with START.
    localparam logic [1:0] OP_WRITE   = 2'b00;
    localparam logic [1:0] OP_CAPTURE = 2'b01;
    localparam logic [1:0] OP_PRESET  = 2'b10;
    localparam logic [1:0] OP_RSVD    = 2'b11;

    // The reserved code is the only one that is never accepted.
    function automatic logic op_is_legal(input logic [1:0] op);
        return (op != OP_RSVD);
    endfunction

    // Operations that need the word on WDATA latched into the serialiser.
    function automatic logic op_uses_wdata(input logic [1:0] op);
        return (op == OP_WRITE) || (op == OP_CAPTURE);
    endfunction

endpackage : aibcr3_scan_pkg
`default_nettype wire

// File: rtl/aibcr3_scan_shreg.sv
`default_nettype none
// ============================================================================
// Module      : aibcr3_scan_shreg
// Description : Dual shift register for the scan sequencer. The transmit half
//               serialises the latched word onto SI, MSB first; the receive
//               half deserialises the chain's SO into the parallel readback.
//               SI comes straight from a flop so the chain input is glitch
//               free.
// Revision    : 1.0 - initial release
// ============================================================================
module aibcr3_scan_shreg #(
    parameter int CHAIN_LEN = 8
) (
    input  logic                 ck_i,
    input  logic                 clear_i,   // synchronous clear of both halves
    input  logic                 load_i,    // latch wdata_i into the transmit half
    input  logic                 shift_i,   // advance both halves by one bit
    input  logic                 set_i,     // force the readback to all ones
    input  logic [CHAIN_LEN-1:0] wdata_i,
    input  logic                 so_i,
    output logic                 si_o,
    output logic [CHAIN_LEN-1:0] rdata_o
);

    logic [CHAIN_LEN-1:0] tx_q;
    logic [CHAIN_LEN-1:0] tx_d;
    logic [CHAIN_LEN-1:0] rx_q;
    logic [CHAIN_LEN-1:0] rx_d;

    // Next-state for both halves; zeros fill the transmit side so SI idles low
    // once the whole word has left.
    always_comb begin
        tx_d = tx_q;
        rx_d = rx_q;
        if (load_i) begin
            tx_d = wdata_i;
        end else if (shift_i) begin
            tx_d = {tx_q[CHAIN_LEN-2:0], 1'b0};
        end
        if (set_i) begin
            rx_d = '1;
        end else if (shift_i) begin
            rx_d = {rx_q[CHAIN_LEN-2:0], so_i};
        end
    end

    // Register both halves; clear wins over every other control.
    always_ff @(posedge ck_i) begin
        if (clear_i) begin
            tx_q <= '0;
            rx_q <= '0;
        end else begin
            tx_q <= tx_d;
            rx_q <= rx_d;
        end
    end

    assign si_o    = tx_q[CHAIN_LEN-1];
    assign rdata_o = rx_q;

endmodule : aibcr3_scan_shreg
`default_nettype wire

// File: rtl/aibcr3_scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aibcr3_scan_chain_ctrl
// Description : Sequencer for a CHAIN_LEN-flop scan chain. Writes a word into
//               the chain, captures functional D data and reads it back, or
//               presets the chain to ones. Every chain control (SE, SI, SDN,
//               CKEN) and status output is flop driven.
// Revision    : 1.0 - initial release
// ============================================================================
module aibcr3_scan_chain_ctrl
    import aibcr3_scan_pkg::*;
#(
    parameter int CHAIN_LEN = 8
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [1:0]           OP,
    input  logic [CHAIN_LEN-1:0] WDATA,
    input  logic                 SO,
    output logic                 SE,
    output logic                 SI,
    output logic                 SDN,
    output logic                 CKEN,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CHAIN_LEN-1:0] RDATA
);

    localparam int              CNT_W    = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    scan_state_e     state_q;
    scan_state_e     state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic se_q;
    logic se_d;
    logic cken_q;
    logic cken_d;
    logic sdn_q;
    logic sdn_d;
    logic busy_q;
    logic busy_d;
    logic done_q;
    logic done_d;

    logic w_accept;
    logic w_load;
    logic w_shift;
    logic w_set;

    // A request is taken only from IDLE and only for a legal op code.
    assign w_accept = (state_q == ST_IDLE) && START && op_is_legal(OP);
    assign w_load   = w_accept && op_uses_wdata(OP);
    assign w_shift  = (state_q == ST_SHIFT);
    assign w_set    = (state_q == ST_PRE);

    // Next state and shift counter; the counter is loaded only on entry to
    // SHIFT and the exit happens on the edge where it reads one, so it
    // never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    case (OP)
                        OP_WRITE: begin
                            state_d = ST_SHIFT;
                            cnt_d   = CNT_LOAD;
                        end
                        OP_CAPTURE: state_d = ST_CAP;
                        OP_PRESET:  state_d = ST_PRE;
                        default:    state_d = ST_IDLE;
                    endcase
                end
            end
            ST_CAP: begin
                state_d = ST_SHIFT;
                cnt_d   = CNT_LOAD;
            end
            ST_SHIFT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_FIN;
                end
            end
            ST_PRE:  state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so that, once
    // registered, they line up exactly with the cycle spent in that state.
    always_comb begin
        se_d   = (state_d == ST_SHIFT);
        cken_d = (state_d == ST_SHIFT) || (state_d == ST_CAP);
        sdn_d  = (state_d != ST_PRE);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
    end

    // State, counter and registered chain controls; reset overrides START.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            se_q    <= 1'b0;
            cken_q  <= 1'b0;
            sdn_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            se_q    <= se_d;
            cken_q  <= cken_d;
            sdn_q   <= sdn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Serialiser / deserialiser. SO is taken on the same edge that shifts
    // the chain, which is the chain's pre-edge value, so no extra stage.
    aibcr3_scan_shreg #(
        .CHAIN_LEN (CHAIN_LEN)
    ) u_shreg (
        .ck_i    (CK),
        .clear_i (RST),
        .load_i  (w_load),
        .shift_i (w_shift),
        .set_i   (w_set),
        .wdata_i (WDATA),
        .so_i    (SO),
        .si_o    (SI),
        .rdata_o (RDATA)
    );

    assign SE   = se_q;
    assign CKEN = cken_q;
    assign SDN  = sdn_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule : aibcr3_scan_chain_ctrl
`default_nettype wire

// File: tb/tb_aibcr3_scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aibcr3_scan_chain_ctrl
// Description : Scoreboard bench for the scan-chain sequencer with a
//               behavioural 8-flop scan chain. The driver pushes the expected
//               word-level outcome of each accepted operation; a monitor pops
//               and compares on every DONE pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aibcr3_scan_chain_ctrl;
    import aibcr3_scan_pkg::*;

    localparam int N = 8;

    logic         CK;
    logic         RST;
    logic         START;
    logic [1:0]   OP;
    logic [N-1:0] WDATA;
    logic         SO;
    logic         SE;
    logic         SI;
    logic         SDN;
    logic         CKEN;
    logic         BUSY;
    logic         DONE;
    logic [N-1:0] RDATA;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Behavioural scan chain: flop 0 next to SI, SO from flop N-1.
    logic [N-1:0] chain_m  = '0;
    logic [N-1:0] chain_d  = '0;
    bit           model_on = 1'b0;

    typedef struct {
        logic [N-1:0] rdata;
        logic [N-1:0] chain;
        int           done_cyc;
        int           se_n;
        int           cap_n;
        int           sdn_n;
    } exp_t;

    exp_t exp_q[$];

    int se_cnt  = 0;
    int cap_cnt = 0;
    int sdn_cnt = 0;

    aibcr3_scan_chain_ctrl #(
        .CHAIN_LEN (N)
    ) dut (
        .CK    (CK),
        .RST   (RST),
        .START (START),
        .OP    (OP),
        .WDATA (WDATA),
        .SO    (SO),
        .SE    (SE),
        .SI    (SI),
        .SDN   (SDN),
        .CKEN  (CKEN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .RDATA (RDATA)
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    always @(posedge CK) cyc <= cyc + 1;

    // Chain: asynchronous active-low preset, otherwise clocked by CK gated
    // with CKEN, shifting SI when SE=1 or loading D when SE=0.
    always @(posedge CK or negedge SDN) begin
        if (model_on) begin
            if (!SDN) begin
                chain_m <= '1;
            end else if (CKEN) begin
                chain_m <= SE ? {chain_m[N-2:0], SI} : chain_d;
            end
        end
    end

    assign SO = chain_m[N-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: counts control activity per operation and scores each DONE.
    initial begin
        exp_t e;
        forever begin
            @(negedge CK);
            if (!BUSY && !DONE) begin
                se_cnt  = 0;
                cap_cnt = 0;
                sdn_cnt = 0;
            end else begin
                if (SE)          se_cnt++;
                if (CKEN && !SE) cap_cnt++;
                if (!SDN)        sdn_cnt++;
                if (DONE) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done cycle=%0d", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rdata",          RDATA,   e.rdata);
                        chk("chain",          chain_m, e.chain);
                        chk("done_cycle",     cyc,     e.done_cyc);
                        chk("se_cycles",      se_cnt,  e.se_n);
                        chk("cap_cycles",     cap_cnt, e.cap_n);
                        chk("sdn_low_cycles", sdn_cnt, e.sdn_n);
                        chk("busy_at_done",   BUSY,    1'b1);
                    end
                    se_cnt  = 0;
                    cap_cnt = 0;
                    sdn_cnt = 0;
                end
            end
        end
    end

    // Drive one request and record what the chain and readback must hold
    // when it completes, derived from the operation's meaning.
    task automatic issue(input logic [1:0] op, input logic [N-1:0] wd);
        exp_t e;
        @(negedge CK);
        START = 1'b1;
        OP    = op;
        WDATA = wd;
        e.se_n  = 0;
        e.cap_n = 0;
        e.sdn_n = 0;
        case (op)
            OP_WRITE: begin
                e.rdata = chain_m;  e.chain = wd;
                e.se_n  = N;        e.done_cyc = cyc + N + 1;
            end
            OP_CAPTURE: begin
                e.rdata = chain_d;  e.chain = wd;
                e.se_n  = N;        e.cap_n = 1;
                e.done_cyc = cyc + N + 2;
            end
            default: begin
                e.rdata = '1;       e.chain = '1;
                e.sdn_n = 1;        e.done_cyc = cyc + 2;
            end
        endcase
        if (op != OP_RSVD) exp_q.push_back(e);
        @(posedge CK);
        #1;
        START = 1'b0;
        OP    = 2'($urandom);
        WDATA = N'($urandom);
    endtask

    task automatic wait_done();
        bit got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CK);
            if (DONE) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL done_timeout cycle=%0d", cyc);
        end
    endtask

    initial begin
        logic [1:0]   rop;
        logic [N-1:0] rwd;
        RST   = 1'b1;
        START = 1'b0;
        OP    = 2'b00;
        WDATA = '0;

        // Reset for two cycles, then check reset values and idle behaviour.
        repeat (2) @(posedge CK);
        #1;
        model_on = 1'b1;
        @(negedge CK);
        RST = 1'b0;
        @(posedge CK);
        #1;
        chk("rst_se",    SE,    1'b0);
        chk("rst_si",    SI,    1'b0);
        chk("rst_sdn",   SDN,   1'b1);
        chk("rst_cken",  CKEN,  1'b0);
        chk("rst_done",  DONE,  1'b0);
        chk("rst_rdata", RDATA, 8'h00);
        for (int i = 0; i < 5; i++) begin
            @(negedge CK);
            chk("idle_busy", BUSY, 1'b0);
        end

        // Directed: WRITE, CAPTURE, PRESET.
        issue(OP_WRITE, 8'hA5);
        wait_done();
        chain_d = 8'h3C;
        issue(OP_CAPTURE, 8'h0F);
        wait_done();
        issue(OP_PRESET, 8'h00);
        wait_done();

        // Reserved op is not accepted.
        issue(OP_RSVD, 8'h77);
        for (int i = 0; i < 3; i++) begin
            @(negedge CK);
            chk("rsvd_busy", BUSY, 1'b0);
        end

        // START during an active WRITE and during FIN is ignored.
        issue(OP_WRITE, 8'h69);
        repeat (2) @(negedge CK);
        START = 1'b1;
        OP    = OP_PRESET;
        WDATA = 8'h00;
        @(posedge CK);
        #1;
        START = 1'b0;
        wait_done();
        START = 1'b1;
        OP    = OP_PRESET;
        @(posedge CK);
        #1;
        START = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CK);
            chk("fin_start_busy", BUSY, 1'b0);
        end

        // Reset in shift cycle 4 of a WRITE aborts it without DONE.
        issue(OP_WRITE, 8'hC3);
        repeat (4) @(negedge CK);
        RST = 1'b1;
        exp_q.delete();
        @(posedge CK);
        #1;
        chk("abort_se",    SE,    1'b0);
        chk("abort_cken",  CKEN,  1'b0);
        chk("abort_sdn",   SDN,   1'b1);
        chk("abort_si",    SI,    1'b0);
        chk("abort_busy",  BUSY,  1'b0);
        chk("abort_done",  DONE,  1'b0);
        chk("abort_rdata", RDATA, 8'h00);
        @(negedge CK);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CK);
            chk("abort_idle", BUSY, 1'b0);
        end
        issue(OP_WRITE, 8'h5A);
        wait_done();

        // Random back-to-back traffic, each request in the first idle cycle.
        for (int i = 0; i < 24; i++) begin
            rop     = 2'($urandom_range(0, 3));
            rwd     = N'($urandom);
            chain_d = N'($urandom);
            issue(rop, rwd);
            if (rop == OP_RSVD) begin
                @(negedge CK);
                chk("rand_rsvd_busy", BUSY, 1'b0);
            end else begin
                wait_done();
            end
        end

        repeat (5) @(negedge CK);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_aibcr3_scan_chain_ctrl
`default_nettype wire
